// File: rtl/cmp_sort_ctrl_if.sv
// Handshake and comparator bus for cmp_sort_ctrl.
// slave is the sorter's view; master is the source/sink/comparator side.
interface cmp_sort_ctrl_if #(
  parameter int W     = 4,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic [W-1:0]     cmp_a;
  logic [W-1:0]     cmp_b;
  logic             cmp_eq;
  logic             cmp_agb;
  logic             cmp_alb;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] swap_cnt;

  modport slave (
    input  in_valid, in_data, cmp_eq, cmp_agb, cmp_alb, out_ready,
    output in_ready, cmp_a, cmp_b, out_valid, out_data, busy, swap_cnt
  );

  modport master (
    output in_valid, in_data, cmp_eq, cmp_agb, cmp_alb, out_ready,
    input  in_ready, cmp_a, cmp_b, out_valid, out_data, busy, swap_cnt
  );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Block sorter: loads DEPTH words, bubble-sorts them with early exit using an
// external magnitude comparator, then streams the block out in ascending order.
module cmp_sort_ctrl #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_sort_ctrl_if.slave bus
);
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state;
  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] pass;
  logic [IDX_W-1:0] j;
  logic             swapped;
  logic [CNT_W-1:0] swap_cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [IDX_W-1:0] j_nxt;
  logic             accept;
  logic             do_swap;
  logic             pass_end;
  logic             any_swap;
  logic             unused_cmp;

  assign j_nxt    = j + IDX_W'(1);
  assign accept   = (state == LOAD) && bus.in_valid && in_ready_q;
  assign do_swap  = (state == SORT) && bus.cmp_agb;
  assign pass_end = (j == (LAST_J - pass));
  assign any_swap = swapped | bus.cmp_agb;

  // Only AGB drives the swap decision, so EQ/ALB are informational here.
  assign unused_cmp = bus.cmp_eq ^ bus.cmp_alb;

  assign bus.cmp_a     = (state == SORT)  ? mem[j]      : '0;
  assign bus.cmp_b     = (state == SORT)  ? mem[j_nxt]  : '0;
  assign bus.out_data  = (state == DRAIN) ? mem[rd_idx] : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.swap_cnt  = swap_cnt_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= bus.in_data;
    end else if (do_swap) begin
      mem[j]     <= mem[j_nxt];
      mem[j_nxt] <= mem[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      wr_idx      <= '0;
      rd_idx      <= '0;
      pass        <= '0;
      j           <= '0;
      swapped     <= 1'b0;
      swap_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (accept) begin
            if (wr_idx == '0) swap_cnt_q <= '0;
            if (wr_idx == LAST_IDX) begin
              state      <= SORT;
              wr_idx     <= '0;
              pass       <= '0;
              j          <= '0;
              swapped    <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end

        SORT: begin
          if (bus.cmp_agb) swap_cnt_q <= swap_cnt_q + CNT_W'(1);
          // The current cycle's swap counts toward the early-exit decision.
          if (pass_end) begin
            if (!any_swap || (pass == LAST_J)) begin
              state       <= DRAIN;
              out_valid_q <= 1'b1;
            end else begin
              pass    <= pass + IDX_W'(1);
              j       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            j       <= j_nxt;
            swapped <= any_swap;
          end
        end

        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_idx == LAST_IDX) begin
              state       <= LOAD;
              rd_idx      <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench for cmp_sort_ctrl with a behavioural comparator and a
// reference sorter that predicts output order, swap count and SORT length.
module tb_cmp_sort_ctrl;
  localparam int D     = 4;
  localparam int W     = 4;
  localparam int CNT_W = 5;

  typedef int blk_t [D];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   hold = 1'b0;

  int errors = 0;
  int checks = 0;

  int exp_q   [$];
  int exp_sw  [$];
  int exp_cyc [$];
  int pair_a  [$];
  int pair_b  [$];

  cmp_sort_ctrl_if #(.W(W), .CNT_W(CNT_W)) bus ();

  cmp_sort_ctrl #(.DEPTH(D), .W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.cmp_eq  = (bus.cmp_a == bus.cmp_b);
  assign bus.cmp_agb = (bus.cmp_a >  bus.cmp_b);
  assign bus.cmp_alb = (bus.cmp_a <  bus.cmp_b);

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: inversion count gives the swap total, selection sort gives the
  // order, and a pass-by-pass bubble sort gives the compare-cycle count.
  function automatic void model(input blk_t v, output blk_t s, output int sw, output int cyc);
    blk_t a;
    int   t;
    bit   any;
    sw = 0;
    for (int i = 0; i < D; i++)
      for (int k = i + 1; k < D; k++)
        if (v[i] > v[k]) sw++;
    s = v;
    for (int i = 0; i < D; i++)
      for (int k = i + 1; k < D; k++)
        if (s[k] < s[i]) begin t = s[i]; s[i] = s[k]; s[k] = t; end
    a = v;
    cyc = 0;
    for (int p = 0; p < D - 1; p++) begin
      any = 1'b0;
      for (int q = 0; q < D - 1 - p; q++) begin
        cyc++;
        if (a[q] > a[q+1]) begin t = a[q]; a[q] = a[q+1]; a[q+1] = t; any = 1'b1; end
      end
      if (!any) break;
    end
  endfunction

  always @(posedge clk) begin
    #2;
    bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: operand and idle checks, SORT length, swap count, output order.
  int sort_cyc = 0;
  bit drain_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sort_cyc   = 0;
      drain_prev = 1'b0;
    end else begin
      if (bus.busy && !bus.out_valid) begin
        if (sort_cyc == 0) begin
          if (pair_a.size() == 0) chk("pair_queue_empty", 1, 0);
          else begin
            chk("first_cmp_a", int'(bus.cmp_a), pair_a.pop_front());
            chk("first_cmp_b", int'(bus.cmp_b), pair_b.pop_front());
          end
        end
        sort_cyc++;
      end else begin
        chk("cmp_idle_zero", int'(bus.cmp_a) + int'(bus.cmp_b), 0);
      end
      if (bus.out_valid && !drain_prev) begin
        if (exp_cyc.size() == 0) chk("unexpected_drain", 1, 0);
        else begin
          chk("sort_cycles", sort_cyc, exp_cyc.pop_front());
          chk("swap_cnt", int'(bus.swap_cnt), exp_sw.pop_front());
        end
        sort_cyc = 0;
      end
      if (bus.out_valid) begin
        chk("drain_in_ready", int'(bus.in_ready), 0);
        chk("drain_busy", int'(bus.busy), 1);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
          else chk("out_data", int'(bus.out_data), exp_q.pop_front());
        end
      end
      drain_prev = bus.out_valid;
    end
  end

  task automatic load_block(input blk_t v, input int maxgap, input bit expect_out);
    blk_t s;
    int   sw, cyc;
    model(v, s, sw, cyc);
    pair_a.push_back(v[0]);
    pair_b.push_back(v[1]);
    if (expect_out) begin
      for (int i = 0; i < D; i++) exp_q.push_back(s[i]);
      exp_sw.push_back(sw);
      exp_cyc.push_back(cyc);
    end
    for (int i = 0; i < D; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom_range(0, 15));
        @(posedge clk); #1;
      end
      chk("in_ready_load", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(v[i]);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("busy_after_load", int'(bus.busy), 1);
    chk("in_ready_sort", int'(bus.in_ready), 0);
  endtask

  // Waits for the block to drain; presents junk input words while busy.
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 300) begin
      if (bus.busy) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = W'($urandom_range(0, 15));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t v;
    int   n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_swap_cnt", int'(bus.swap_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    v = '{1, 2, 3, 4};   load_block(v, 0, 1); wait_idle();
    v = '{8, 6, 3, 1};   load_block(v, 1, 1); wait_idle();
    v = '{5, 5, 2, 5};   load_block(v, 1, 1); wait_idle();

    hold = 1'b1;
    v = '{11, 10, 6, 0}; load_block(v, 0, 1);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("drain_timeout", 1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_out_data", int'(bus.out_data), 0);
    end
    @(posedge clk); #1;
    hold = 1'b0;
    wait_idle();

    v = '{8, 1, 4, 14};  load_block(v, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midsort_rst_in_ready", int'(bus.in_ready), 1);
    chk("midsort_rst_swap_cnt", int'(bus.swap_cnt), 0);
    chk("midsort_rst_out_valid", int'(bus.out_valid), 0);
    chk("midsort_rst_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '{4, 14, 1, 8};  load_block(v, 0, 1); wait_idle();

    v = '{7, 3, 9, 2};   load_block(v, 3, 1); wait_idle();

    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < D; i++) v[i] = $urandom_range(0, (b % 2 != 0) ? 3 : 15);
      load_block(v, 2, 1);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size() + exp_cyc.size() + pair_a.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
